// File: rtl/data_mem_if_pkg.sv
// Shared definitions for the data-memory stall handshake: sign-mask encodings,
// RISC-V load/store funct3 codes, default address map and initiator state codes.
package data_mem_if_pkg;

    // Width field of the memory sign mask (bits [2:0]); bit 3 selects sign extension.
    localparam logic [2:0] MASK_BYTE = 3'b001;
    localparam logic [2:0] MASK_HALF = 3'b011;
    localparam logic [2:0] MASK_WORD = 3'b111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [31:0] DEFAULT_DMEM_BASE = 32'h0000_1000;
    localparam logic [31:0] DEFAULT_DMEM_SIZE = 32'h0000_1000;
    localparam logic [31:0] DEFAULT_LED_ADDR  = 32'h0000_2000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_DONE    = 3'd4,
        ST_FAULT   = 3'd5
    } state_e;

    // Sign mask for a legal funct3: width bits plus sign bit (~funct3[2]).
    function automatic logic [3:0] make_sign_mask(input logic [2:0] funct3,
                                                  input logic [2:0] width);
        return {~funct3[2], width};
    endfunction

endpackage

// File: rtl/mem_access_check.sv
// Combinational load/store legality check: decodes funct3 into the memory sign
// mask and flags illegal width codes, misalignment and out-of-map addresses.
module mem_access_check
    import data_mem_if_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE = DEFAULT_DMEM_BASE,
    parameter logic [31:0] DMEM_SIZE = DEFAULT_DMEM_SIZE,
    parameter logic [31:0] LED_ADDR  = DEFAULT_LED_ADDR
) (
    input  logic [2:0]  funct3,
    input  logic        write,
    input  logic [31:0] addr,
    output logic [3:0]  sign_mask,
    output logic        fault
);

    logic [2:0]  width;
    logic        op_bad;
    logic        misaligned;
    logic        in_dmem;
    logic        led_store;
    logic [32:0] dmem_end;

    // One extra bit so BASE+SIZE at the top of the address space cannot wrap.
    assign dmem_end = {1'b0, DMEM_BASE} + {1'b0, DMEM_SIZE};

    always_comb begin
        width  = 3'b000;
        op_bad = 1'b0;
        case (funct3)
            F3_LB, F3_LBU: width = MASK_BYTE;
            F3_LH, F3_LHU: width = MASK_HALF;
            F3_LW:         width = MASK_WORD;
            default:       op_bad = 1'b1;
        endcase
        // Stores have no unsigned variants.
        if (write && funct3[2]) begin
            op_bad = 1'b1;
        end
    end

    assign misaligned = ((width == MASK_HALF) && addr[0]) ||
                        ((width == MASK_WORD) && (addr[1:0] != 2'b00));

    assign in_dmem   = (addr >= DMEM_BASE) && ({1'b0, addr} < dmem_end);
    assign led_store = write && (addr == LED_ADDR);

    assign fault     = op_bad | misaligned | ~(in_dmem | led_store);
    assign sign_mask = op_bad ? 4'b0000 : make_sign_mask(funct3, width);

endmodule

// File: rtl/data_mem_initiator.sv
// Processor-side initiator for the data-memory stall handshake: issues one
// strobed access per request, follows the clk_stall pulse and returns data or a fault.
module data_mem_initiator
    import data_mem_if_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE = DEFAULT_DMEM_BASE,
    parameter logic [31:0] DMEM_SIZE = DEFAULT_DMEM_SIZE,
    parameter logic [31:0] LED_ADDR  = DEFAULT_LED_ADDR,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,

    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,

    output logic        mem_enable,
    output logic        mem_memread,
    output logic        mem_memwrite,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_sign_mask,
    input  logic [31:0] mem_read_data,
    input  logic        mem_clk_stall
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_load_q, is_load_d;

    logic               resp_valid_q, resp_valid_d;
    logic               resp_fault_q, resp_fault_d;
    logic [31:0]        resp_rdata_q, resp_rdata_d;

    logic               mem_enable_q, mem_enable_d;
    logic               mem_memread_q, mem_memread_d;
    logic               mem_memwrite_q, mem_memwrite_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_write_data_q, mem_write_data_d;
    logic [3:0]         mem_sign_mask_q, mem_sign_mask_d;

    logic [3:0]         chk_mask;
    logic               chk_fault;
    logic               can_accept;
    logic               accept;

    mem_access_check #(
        .DMEM_BASE (DMEM_BASE),
        .DMEM_SIZE (DMEM_SIZE),
        .LED_ADDR  (LED_ADDR)
    ) u_check (
        .funct3    (req_funct3),
        .write     (req_write),
        .addr      (req_addr),
        .sign_mask (chk_mask),
        .fault     (chk_fault)
    );

    // Request handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both high; req_valid must hold its fields until then. Ready is
    // withheld while the memory still shows stall, so a new strobe can never land
    // on a transaction the memory has not finished (e.g. one cut short by reset).
    assign can_accept = ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                         (state_q == ST_FAULT)) && !mem_clk_stall;
    assign req_ready  = can_accept;
    assign accept     = req_valid && can_accept;

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        is_load_d        = is_load_q;
        resp_valid_d     = 1'b0;
        resp_fault_d     = 1'b0;
        resp_rdata_d     = resp_rdata_q;
        mem_enable_d     = 1'b1;
        mem_memread_d    = 1'b0;
        mem_memwrite_d   = 1'b0;
        mem_addr_d       = mem_addr_q;
        mem_write_data_d = mem_write_data_q;
        mem_sign_mask_d  = mem_sign_mask_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_FAULT: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (chk_fault) begin
                        state_d      = ST_FAULT;
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                    end else begin
                        state_d          = ST_ISSUE;
                        is_load_d        = ~req_write;
                        mem_enable_d     = 1'b0;
                        mem_memread_d    = ~req_write;
                        mem_memwrite_d   = req_write;
                        mem_addr_d       = req_addr;
                        mem_write_data_d = req_wdata;
                        mem_sign_mask_d  = chk_mask;
                    end
                end
            end

            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT_HI;
            end

            ST_WAIT_HI: begin
                if (mem_clk_stall) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_LO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = ST_FAULT;
                    resp_valid_d = 1'b1;
                    resp_fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_WAIT_LO: begin
                if (!mem_clk_stall) begin
                    state_d      = ST_DONE;
                    resp_valid_d = 1'b1;
                    if (is_load_q) begin
                        resp_rdata_d = mem_read_data;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = ST_FAULT;
                    resp_valid_d = 1'b1;
                    resp_fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            is_load_q        <= 1'b0;
            resp_valid_q     <= 1'b0;
            resp_fault_q     <= 1'b0;
            resp_rdata_q     <= '0;
            mem_enable_q     <= 1'b1;
            mem_memread_q    <= 1'b0;
            mem_memwrite_q   <= 1'b0;
            mem_addr_q       <= '0;
            mem_write_data_q <= '0;
            mem_sign_mask_q  <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            is_load_q        <= is_load_d;
            resp_valid_q     <= resp_valid_d;
            resp_fault_q     <= resp_fault_d;
            resp_rdata_q     <= resp_rdata_d;
            mem_enable_q     <= mem_enable_d;
            mem_memread_q    <= mem_memread_d;
            mem_memwrite_q   <= mem_memwrite_d;
            mem_addr_q       <= mem_addr_d;
            mem_write_data_q <= mem_write_data_d;
            mem_sign_mask_q  <= mem_sign_mask_d;
        end
    end

    assign resp_valid     = resp_valid_q;
    assign resp_fault     = resp_fault_q;
    assign resp_rdata     = resp_rdata_q;
    assign mem_enable     = mem_enable_q;
    assign mem_memread    = mem_memread_q;
    assign mem_memwrite   = mem_memwrite_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_write_data_q;
    assign mem_sign_mask  = mem_sign_mask_q;

endmodule

// File: tb/tb_data_mem_initiator.sv
// Bench for data_mem_initiator: a stalling data-memory model, directed and
// randomised load/store requests, and an expected-response queue.
module tb_data_mem_initiator;

    localparam int unsigned TIMEOUT = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_fault;
    logic [31:0] resp_rdata;
    logic        mem_enable, mem_memread, mem_memwrite;
    logic [31:0] mem_addr, mem_write_data;
    logic [3:0]  mem_sign_mask;
    logic [31:0] mem_read_data = 32'h0;
    logic        mem_clk_stall = 1'b0;

    data_mem_initiator #(.TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_fault     (resp_fault),
        .mem_enable     (mem_enable),
        .mem_memread    (mem_memread),
        .mem_memwrite   (mem_memwrite),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_sign_mask  (mem_sign_mask),
        .mem_read_data  (mem_read_data),
        .mem_clk_stall  (mem_clk_stall)
    );

    // ---------------- memory model ----------------
    logic [31:0] mem_arr [0:1023];
    int          hold_extra = 0;
    logic        never_stall = 1'b0;
    int          stall_left = 0;
    logic        pend_rd = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    logic [3:0]  pend_mask = 4'h0;

    function automatic logic model_in_dmem(input logic [31:0] a);
        return (a >= 32'h1000) && (a < 32'h2000);
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] old_w, input logic [31:0] wd,
                                                input logic [1:0] off, input logic [2:0] width);
        logic [31:0] m;
        case (width)
            3'b001:  m = 32'h0000_00FF << (8 * off);
            3'b011:  m = 32'h0000_FFFF << (8 * off);
            default: m = 32'hFFFF_FFFF;
        endcase
        return (old_w & ~m) | ((wd << (8 * off)) & m);
    endfunction

    function automatic logic [31:0] model_extend(input logic [31:0] word, input logic [1:0] off,
                                                 input logic [3:0] mask);
        logic [31:0] sh;
        sh = word >> (8 * off);
        case (mask[2:0])
            3'b001:  return mask[3] ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
            3'b011:  return mask[3] ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
            default: return word;
        endcase
    endfunction

    // Stall rises the cycle after the strobe and falls 1+hold_extra cycles later
    // with read data valid; the model has no reset.
    always @(posedge clk) begin
        if (!mem_enable && (mem_memread || mem_memwrite)) begin
            if (!never_stall) begin
                mem_clk_stall <= 1'b1;
                stall_left    <= hold_extra;
                pend_rd       <= mem_memread;
                pend_addr     <= mem_addr;
                pend_mask     <= mem_sign_mask;
                if (mem_memwrite && model_in_dmem(mem_addr))
                    mem_arr[mem_addr[11:2]] <= model_merge(mem_arr[mem_addr[11:2]], mem_write_data,
                                                           mem_addr[1:0], mem_sign_mask[2:0]);
            end
        end else if (mem_clk_stall) begin
            if (stall_left > 0) begin
                stall_left <= stall_left - 1;
            end else begin
                mem_clk_stall <= 1'b0;
                if (pend_rd)
                    mem_read_data <= model_extend(mem_arr[pend_addr[11:2]], pend_addr[1:0], pend_mask);
            end
        end
    end

    // Strobe monitor: counts enable/read/write cycles and records the last strobe.
    int          en_cnt = 0, rd_cnt = 0, wr_cnt = 0;
    logic [3:0]  last_mask = 4'h0;
    logic [31:0] last_addr = 32'h0, last_wdata = 32'h0;
    always @(posedge clk) begin
        if (mem_memread)  rd_cnt <= rd_cnt + 1;
        if (mem_memwrite) wr_cnt <= wr_cnt + 1;
        if (!mem_enable) begin
            en_cnt     <= en_cnt + 1;
            last_mask  <= mem_sign_mask;
            last_addr  <= mem_addr;
            last_wdata <= mem_write_data;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic ref_fault(input logic w, input logic [2:0] f3, input logic [31:0] a);
        logic bad_op, mis, ok_addr;
        bad_op  = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) || (w && f3[2]);
        mis     = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00));
        ok_addr = ((a >= 32'h1000) && (a < 32'h2000)) || (w && (a == 32'h2000));
        return bad_op || mis || !ok_addr;
    endfunction

    function automatic logic [3:0] ref_mask(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return {~f3[2], 3'b001};
            2'b01:   return {~f3[2], 3'b011};
            default: return {~f3[2], 3'b111};
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        w = mem_arr[a[11:2]];
        b = w[8*a[1:0] +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q[$];
    logic [31:0] last_rdata = 32'h0;
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s/%s: observed %h expected %h", tag, what, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge; returns at a falling edge one cycle after the response.
    task automatic do_req(input string tag, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d, input logic timeout_case);
        logic        chk_f, exp_f;
        logic [31:0] exp_rd;
        logic [32:0] exp_e;
        int          n, acc, exp_lat, rd0, wr0, en0;
        chk_f   = ref_fault(w, f3, a);
        exp_f   = chk_f || timeout_case;
        exp_rd  = (!exp_f && !w) ? ref_read(a, f3) : last_rdata;
        exp_lat = chk_f ? 1 : (timeout_case ? int'(TIMEOUT) + 2 : 4);
        rd0 = rd_cnt; wr0 = wr_cnt; en0 = en_cnt;

        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
        n = 0;
        while (!req_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk(tag, "req_ready", {31'h0, req_ready}, 32'd1);
        acc = cyc;
        exp_q.push_back({exp_f, exp_rd});
        @(posedge clk);
        #1;
        req_valid = 1'b0;

        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 64);
        chk(tag, "resp_valid", {31'h0, resp_valid}, 32'd1);
        exp_e = exp_q.pop_front();
        chk(tag, "latency", cyc - acc, exp_lat);
        chk(tag, "resp_fault", {31'h0, resp_fault}, {31'h0, exp_e[32]});
        chk(tag, "resp_rdata", resp_rdata, exp_e[31:0]);
        chk(tag, "strobe_cycles", en_cnt - en0, chk_f ? 0 : 1);
        chk(tag, "read_strobes", rd_cnt - rd0, (!chk_f && !w) ? 1 : 0);
        chk(tag, "write_strobes", wr_cnt - wr0, (!chk_f && w) ? 1 : 0);
        if (!chk_f) begin
            chk(tag, "sign_mask", {28'h0, last_mask}, {28'h0, ref_mask(f3)});
            chk(tag, "mem_addr", last_addr, a);
            if (w) chk(tag, "write_data", last_wdata, d);
        end
        if (!exp_f && !w) last_rdata = exp_rd;
        @(negedge clk);
        chk(tag, "resp_pulse_end", {31'h0, resp_valid}, 32'd0);
    endtask

    logic [31:0] addr_tab [10] = '{32'h1000, 32'h1001, 32'h1002, 32'h1FFC, 32'h1FFE,
                                   32'h1FFF, 32'h0FFF, 32'h2000, 32'h2004, 32'h3000};
    logic [2:0]  f3_tab [7] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        for (int i = 0; i < 1024; i++) mem_arr[i] <= 32'h0;
        mem_arr[0]    <= 32'h1234_56F0;
        mem_arr[1]    <= 32'hDEAD_BEEF;
        mem_arr[1023] <= 32'h8001_7F80;
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);

        chk("reset", "req_ready", {31'h0, req_ready}, 32'd1);
        chk("reset", "resp_valid", {31'h0, resp_valid}, 32'd0);
        chk("reset", "resp_fault", {31'h0, resp_fault}, 32'd0);
        chk("reset", "resp_rdata", resp_rdata, 32'h0);
        chk("reset", "mem_enable", {31'h0, mem_enable}, 32'd1);
        chk("reset", "mem_memread", {31'h0, mem_memread}, 32'd0);
        chk("reset", "mem_memwrite", {31'h0, mem_memwrite}, 32'd0);
        chk("reset", "mem_addr", mem_addr, 32'h0);
        chk("reset", "mem_write_data", mem_write_data, 32'h0);
        chk("reset", "mem_sign_mask", {28'h0, mem_sign_mask}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        do_req("lw_1004", 1'b0, 3'b010, 32'h1004, 32'h0, 1'b0);
        do_req("sb_1003", 1'b1, 3'b000, 32'h1003, 32'h0000_00A5, 1'b0);
        do_req("lh_1001", 1'b0, 3'b001, 32'h1001, 32'h0, 1'b0);
        do_req("lw_led", 1'b0, 3'b010, 32'h2000, 32'h0, 1'b0);
        do_req("sw_led", 1'b1, 3'b010, 32'h2000, 32'h0000_0055, 1'b0);
        do_req("lw_1ffc", 1'b0, 3'b010, 32'h1FFC, 32'h0, 1'b0);
        do_req("lw_0ffc", 1'b0, 3'b010, 32'h0FFC, 32'h0, 1'b0);
        do_req("s_f3_100", 1'b1, 3'b100, 32'h1000, 32'h1, 1'b0);

        never_stall = 1'b1;
        do_req("lw_timeout", 1'b0, 3'b010, 32'h1008, 32'h0, 1'b1);
        never_stall = 1'b0;
        do_req("lbu_1000", 1'b0, 3'b100, 32'h1000, 32'h0, 1'b0);

        // Reset lands in WAIT_HI while the memory keeps stall high two more cycles.
        hold_extra = 2;
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h1004; req_wdata = 32'h0;
        n = 0;
        while (!req_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid", "req_ready_accept", {31'h0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid", "issue_enable", {31'h0, mem_enable}, 32'd0);
        @(negedge clk);
        chk("rst_mid", "wait_enable", {31'h0, mem_enable}, 32'd1);
        chk("rst_mid", "wait_ready", {31'h0, req_ready}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid", "ready_gated_1", {31'h0, req_ready}, 32'd0);
        chk("rst_mid", "resp_valid", {31'h0, resp_valid}, 32'd0);
        chk("rst_mid", "resp_rdata", resp_rdata, 32'h0);
        chk("rst_mid", "mem_memread", {31'h0, mem_memread}, 32'd0);
        @(negedge clk);
        chk("rst_mid", "ready_gated_2", {31'h0, req_ready}, 32'd0);
        @(negedge clk);
        chk("rst_mid", "ready_after_stall", {31'h0, req_ready}, 32'd1);
        chk("rst_mid", "no_resp", {31'h0, resp_valid}, 32'd0);
        hold_extra = 0;
        last_rdata = 32'h0;
        do_req("lw_after_rst", 1'b0, 3'b010, 32'h1004, 32'h0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            do_req("rand", 1'($urandom_range(0, 1)), f3_tab[$urandom_range(0, 6)],
                   addr_tab[$urandom_range(0, 9)], $urandom, 1'b0);
        end
        do_req("lh_1ffe", 1'b0, 3'b001, 32'h1FFE, 32'h0, 1'b0);

        chk("end", "queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
